// File: rtl/quadrature_velocity_counter.sv
// Multi-channel 4x quadrature decoder with a shared measurement window.
// Each channel accumulates signed, saturating edge counts that are published together at window end.
module quadrature_velocity_counter #(
    parameter int NUM_CH        = 2,
    parameter int COUNT_WIDTH   = 16,
    parameter int WINDOW_CYCLES = 1250000,
    parameter int SYNC_STAGES   = 2
) (
    input  logic                          clk_in,
    input  logic                          reset_in,
    input  logic [NUM_CH-1:0]             quad_a_in,
    input  logic [NUM_CH-1:0]             quad_b_in,
    input  logic                          error_clr_in,
    output logic [NUM_CH*COUNT_WIDTH-1:0] count_o,
    output logic                          count_valid_o,
    output logic [NUM_CH-1:0]             sat_o,
    output logic [NUM_CH-1:0]             error_o
);

    localparam int WIN_W = (WINDOW_CYCLES > 1) ? $clog2(WINDOW_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
    localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

    localparam logic [COUNT_WIDTH-1:0] ACC_MAX = {1'b0, {(COUNT_WIDTH-1){1'b1}}};
    localparam logic [COUNT_WIDTH-1:0] ACC_MIN = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
    localparam logic [COUNT_WIDTH:0]   SUM_ONE = (COUNT_WIDTH+1)'(1);

    // Position of a sampled {a,b} state along the forward Gray sequence 00,10,11,01.
    function automatic logic [1:0] phase(input logic [1:0] s);
        logic [1:0] p;
        case (s)
            2'b00:   p = 2'd0;
            2'b10:   p = 2'd1;
            2'b11:   p = 2'd2;
            default: p = 2'd3;
        endcase
        return p;
    endfunction

    logic [NUM_CH-1:0] sync_a [SYNC_STAGES];
    logic [NUM_CH-1:0] sync_b [SYNC_STAGES];
    logic [WIN_W-1:0]  win_cnt;
    logic              terminal;
    logic              prime;

    // Synchroniser chain is deliberately not reset so the decoder sees the true pin state
    // as soon as reset drops; the prime cycle then absorbs it without producing an edge.
    always_ff @(posedge clk_in) begin
        sync_a[0] <= quad_a_in;
        sync_b[0] <= quad_b_in;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_a[i] <= sync_a[i-1];
            sync_b[i] <= sync_b[i-1];
        end
    end

    assign terminal = (win_cnt == '0);

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            win_cnt       <= WIN_LAST;
            prime         <= 1'b1;
            count_valid_o <= 1'b0;
        end else begin
            prime         <= 1'b0;
            count_valid_o <= terminal;
            if (terminal) begin
                win_cnt <= WIN_LAST;
            end else begin
                win_cnt <= win_cnt - WIN_ONE;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]             cur_s;
        logic [1:0]             prev_s;
        logic [1:0]             step;
        logic                   inc;
        logic                   dec;
        logic                   illegal;
        logic [COUNT_WIDTH-1:0] acc;
        logic [COUNT_WIDTH:0]   sum;
        logic [COUNT_WIDTH-1:0] next_val;
        logic                   clamp;
        logic                   win_sat;
        logic [COUNT_WIDTH-1:0] count_r;
        logic                   sat_r;
        logic                   err_r;

        assign cur_s   = {sync_a[SYNC_STAGES-1][g], sync_b[SYNC_STAGES-1][g]};
        assign step    = phase(cur_s) - phase(prev_s);
        assign inc     = !prime && (step == 2'd1);
        assign dec     = !prime && (step == 2'd3);
        assign illegal = !prime && (step == 2'd2);

        // One extra bit catches overflow: sign bits disagree exactly when the result left range.
        always_comb begin
            sum = {acc[COUNT_WIDTH-1], acc};
            if (inc) begin
                sum = sum + SUM_ONE;
            end else if (dec) begin
                sum = sum - SUM_ONE;
            end
            clamp    = 1'b0;
            next_val = sum[COUNT_WIDTH-1:0];
            if (!sum[COUNT_WIDTH] && sum[COUNT_WIDTH-1]) begin
                clamp    = 1'b1;
                next_val = ACC_MAX;
            end else if (sum[COUNT_WIDTH] && !sum[COUNT_WIDTH-1]) begin
                clamp    = 1'b1;
                next_val = ACC_MIN;
            end
        end

        always_ff @(posedge clk_in) begin
            prev_s <= cur_s;
            if (reset_in) begin
                acc     <= '0;
                win_sat <= 1'b0;
                count_r <= '0;
                sat_r   <= 1'b0;
                err_r   <= 1'b0;
            end else begin
                if (terminal) begin
                    count_r <= next_val;
                    sat_r   <= win_sat | clamp;
                    acc     <= '0;
                    win_sat <= 1'b0;
                end else begin
                    acc     <= next_val;
                    win_sat <= win_sat | clamp;
                end
                if (illegal) begin
                    err_r <= 1'b1;
                end else if (error_clr_in) begin
                    err_r <= 1'b0;
                end
            end
        end

        assign count_o[g*COUNT_WIDTH +: COUNT_WIDTH] = count_r;
        assign sat_o[g]   = sat_r;
        assign error_o[g] = err_r;
    end

endmodule
